count_hist_display: RTL and testbench

- Downstream consumer of the 4-bit up/down counter's q and m signals.
- Detects every change of the count value and keeps a 4-deep history of the last distinct values.
- Flags wrap-around events.
- Time-multiplexes the history onto a 4-digit common-anode seven-segment display (digit 0 = newest value).

---
 rtl/count_disp_pkg.sv | 11 +
 rtl/hex_to_seg7.sv | 9 +
 rtl/count_hist_display.sv | 71 +++++++
 tb/tb_count_hist_display.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/count_disp_pkg.sv
// count_disp_pkg: shared constants and types for the count history display
package count_disp_pkg;
  localparam int DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Active-low {g,f,e,d,c,b,a} glyphs for 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef logic [1:0] digit_idx_t;
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex digit to active-low seven-segment pattern
module hex_to_seg7
  import count_disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[hex];
endmodule

// File: rtl/count_hist_display.sv
// count_hist_display: change history of an up/down counter shown on a 4-digit display
// Optional WRAP_CNT_EN adds a saturating wrap event counter output wrap_cnt.
module count_hist_display
  import count_disp_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int CNT_MAX  = 15
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [3:0]        q_in,
  input  logic              m_in,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              wrap,
  output logic              dir_led
`ifdef WRAP_CNT_EN
  ,
  output logic [7:0]        wrap_cnt
`endif
);
  logic [3:0] hist [DIGITS];
  logic [DIGITS-1:0] valid;
  logic [3:0] q_reg;
  logic primed, chg, wrap_d, pre_end;
  logic [15:0] pre;
  digit_idx_t idx;
  logic [6:0] seg_d;
  assign chg = primed && (q_in != q_reg);
  assign wrap_d = chg && (m_in ? (q_reg == 4'd0 && q_in == 4'(CNT_MAX))
                               : (q_reg == 4'(CNT_MAX) && q_in == 4'd0));
  assign pre_end = pre == 16'(SCAN_DIV - 1);
  hex_to_seg7 u_dec (.hex(hist[idx]), .seg(seg_d));
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      hist    <= '{default: '0};
      valid   <= '0;
      q_reg   <= '0;
      primed  <= 1'b0;
      pre     <= '0;
      idx     <= '0;
      seg     <= SEG_BLANK;
      an      <= '1;
      wrap    <= 1'b0;
      dir_led <= 1'b0;
    end else begin
      if (!primed) begin
        q_reg   <= q_in;
        hist[0] <= q_in;
        valid   <= 4'b0001;
        primed  <= 1'b1;
      end else if (chg) begin
        q_reg <= q_in;
        hist  <= '{q_in, hist[0], hist[1], hist[2]};
        valid <= {valid[2:0], 1'b1};
      end
      pre     <= pre_end ? '0 : pre + 16'd1;
      idx     <= idx + digit_idx_t'(pre_end);
      an      <= ~(4'b0001 << idx);
      seg     <= valid[idx] ? seg_d : SEG_BLANK;
      wrap    <= wrap_d;
      dir_led <= m_in;
    end
  end
`ifdef WRAP_CNT_EN
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) wrap_cnt <= '0;
    else if (wrap_d && wrap_cnt != 8'hFF) wrap_cnt <= wrap_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_count_hist_display.sv
// tb_count_hist_display: directed stimulus checked against a queue-based history model
module tb_count_hist_display;
  localparam int SD = 4;
  logic clk = 0, clear = 0, m_in = 0, started = 0;
  logic [3:0] q_in = 4'd3;
  logic [6:0] seg;
  logic [3:0] an;
  logic wrap, dir_led;
  int n_checks = 0, n_fail = 0, wrap_seen = 0;
`ifdef WRAP_CNT_EN
  logic [7:0] wrap_cnt;
`endif

  count_hist_display #(.SCAN_DIV(SD), .CNT_MAX(15)) dut (
    .clk(clk), .clear(clear), .q_in(q_in), .m_in(m_in),
    .seg(seg), .an(an), .wrap(wrap), .dir_led(dir_led)
`ifdef WRAP_CNT_EN
    , .wrap_cnt(wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: newest-first queue of distinct values; lit digit follows elapsed clocks
  logic [3:0] mh [$];
  int n = 0, d = 0, e_wcnt = 0;
  logic [6:0] e_seg = 7'h7F;
  logic [3:0] e_an = 4'hF;
  logic e_wrap = 0, e_dir = 0;
  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      mh.delete(); n = 0; e_seg = 7'h7F; e_an = 4'hF; e_wrap = 0; e_dir = 0; e_wcnt = 0;
    end else begin
      d = (n / SD) % 4;
      e_an = ~(4'b0001 << d);
      e_seg = (mh.size() > d) ? hex_tab[mh[d]] : 7'h7F;
      e_dir = m_in;
      e_wrap = 0;
      if (mh.size() == 0) mh.push_front(q_in);
      else if (q_in != mh[0]) begin
        e_wrap = (!m_in && mh[0] == 4'd15 && q_in == 4'd0) || (m_in && mh[0] == 4'd0 && q_in == 4'd15);
        mh.push_front(q_in);
        if (mh.size() > 4) void'(mh.pop_back());
      end
      if (e_wrap && e_wcnt < 255) e_wcnt++;
      n++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (started) begin
    chk("seg", 32'(seg), 32'(e_seg));
    chk("an", 32'(an), 32'(e_an));
    chk("wrap", 32'(wrap), 32'(e_wrap));
    chk("dir_led", 32'(dir_led), 32'(e_dir));
`ifdef WRAP_CNT_EN
    chk("wrap_cnt", 32'(wrap_cnt), 32'(e_wcnt));
`endif
    if (wrap === 1'b1) wrap_seen++;
  end

  task automatic tick(input logic [3:0] q, input logic m);
    q_in = q; m_in = m;
    @(negedge clk);
  endtask

  task automatic hold(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] t);
    int k = 0;
    while (an !== t && k < 40) begin @(negedge clk); k++; end
    if (an !== t) chk("wait_an", 32'(an), 32'(t));
  endtask

  task automatic seg_at(input string name, input logic [3:0] t, input logic [6:0] s);
    wait_an(t);
    chk(name, 32'(seg), 32'(s));
  endtask

  initial begin
    hold(3);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_wrap", 32'(wrap), 32'h0);
    clear = 1; started = 1;
    tick(4'd3, 0);
    tick(4'd3, 0);
    chk("prime_seg", 32'(seg), 32'h30);
    chk("prime_an", 32'(an), 32'hE);
    seg_at("blank_d1", 4'b1101, 7'h7F);
    seg_at("blank_d3", 4'b0111, 7'h7F);
    wrap_seen = 0;
    tick(4'd4, 0); tick(4'd5, 0);
    repeat (10) tick(4'd5, 0);
    seg_at("hist_d0", 4'b1110, 7'h12);
    seg_at("hist_d2", 4'b1011, 7'h30);
    seg_at("hist_d3", 4'b0111, 7'h7F);
    chk("no_wrap_up", 32'(wrap_seen), 32'd0);
    wrap_seen = 0;
    tick(4'd14, 0); tick(4'd15, 0); tick(4'd0, 0); hold(3);
    chk("wrap_up", 32'(wrap_seen), 32'd1);
    wrap_seen = 0;
    tick(4'd14, 1); tick(4'd15, 1); tick(4'd0, 1); hold(3);
    chk("no_wrap_dir", 32'(wrap_seen), 32'd0);
    wrap_seen = 0;
    tick(4'd1, 1); tick(4'd0, 1); tick(4'd15, 1); hold(3);
    chk("wrap_down", 32'(wrap_seen), 32'd1);
    wrap_seen = 0;
    tick(4'd2, 0); tick(4'd4, 0); hold(2);
    chk("no_wrap_jump", 32'(wrap_seen), 32'd0);
    tick(4'hD, 0); tick(4'hC, 1); tick(4'hB, 1); tick(4'hA, 1);
    hold(2);
    seg_at("glyph_A", 4'b1110, 7'h08);
    seg_at("glyph_b", 4'b1101, 7'h03);
    seg_at("glyph_C", 4'b1011, 7'h46);
    seg_at("glyph_d", 4'b0111, 7'h21);
    wait_an(4'b1011);
    #3 clear = 0;
    #1;
    chk("async_an", 32'(an), 32'hF);
    chk("async_seg", 32'(seg), 32'h7F);
    chk("async_wrap", 32'(wrap), 32'h0);
    @(negedge clk);
    clear = 1;
    tick(4'd9, 0);
    tick(4'd9, 0);
    chk("reprime_seg", 32'(seg), 32'h10);
    seg_at("reprime_d1", 4'b1101, 7'h7F);
`ifdef WRAP_CNT_EN
    tick(4'd1, 1); tick(4'd0, 1); tick(4'd15, 1); hold(2);
    chk("wcnt_one", 32'(wrap_cnt), 32'd1);
    for (int i = 0; i < 300; i++) begin tick(4'd0, 1); tick(4'd15, 1); end
    hold(2);
    chk("wcnt_sat", 32'(wrap_cnt), 32'hFF);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
